// File: rtl/mtm_alu_sout_rx.sv
// Serial response receiver for the ALU sout line: decodes 11-bit frames into a result word.
// Optional CRC-3 check of the normal-response CTL byte is enabled by defining MTM_RX_CRC_CHECK_EN.
module mtm_alu_sout_rx #(
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        res_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [7:0]  res_ctl,
  output logic        res_err,
  output logic        frame_err,
  output logic        pkt_err,
  output logic        overrun
);

  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BYTES);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TYPE, DATA, STOP, WAIT_HI} state_e;

  state_e        state_q, state_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic          type_q, type_d;
  logic [7:0]    byte_q, byte_d;
  logic [31:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idle_q, idle_d;

  logic          resValid_q, resValid_d;
  logic [31:0]   resData_q, resData_d;
  logic [7:0]    resCtl_q, resCtl_d;
  logic          resErr_q, resErr_d;
  logic          frameErr_q, frameErr_d;
  logic          pktErr_q, pktErr_d;
  logic          overrun_q, overrun_d;

  logic          complete;
  logic          cplErr;
  logic [31:0]   cplData;
  logic          crcOk;

`ifdef MTM_RX_CRC_CHECK_EN
  logic [2:0]    crc_q, crc_d;
  logic          crcBit;
  logic          crcFb;
`endif

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    type_d     = type_q;
    byte_d     = byte_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    idle_d     = '0;
    resValid_d = resValid_q;
    resData_d  = resData_q;
    resCtl_d   = resCtl_q;
    resErr_d   = resErr_q;
    frameErr_d = 1'b0;
    pktErr_d   = 1'b0;
    overrun_d  = 1'b0;
    complete   = 1'b0;
    cplErr     = 1'b0;
    cplData    = '0;
`ifdef MTM_RX_CRC_CHECK_EN
    crc_d      = crc_q;
    crcBit     = 1'b0;
    crcFb      = 1'b0;
    crcOk      = (crc_q == byte_q[2:0]);
`else
    crcOk      = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        // Only a partially received packet can time out.
        if (cnt_q != '0) begin
          if (idle_q == IDLE_MAX) begin
            pktErr_d = 1'b1;
            cnt_d    = '0;
          end else if (sin) begin
            idle_d = idle_q + TW'(1);
          end
        end
        if (!sin) state_d = TYPE;
      end
      TYPE: begin
        type_d   = sin;
        bitCnt_d = 3'd7;
        state_d  = DATA;
`ifdef MTM_RX_CRC_CHECK_EN
        if (cnt_q == '0) crc_d = '0;
`endif
      end
      DATA: begin
        byte_d = {byte_q[6:0], sin};
`ifdef MTM_RX_CRC_CHECK_EN
        // CTL bit 7 enters the CRC as 0; the received crc field itself is excluded.
        if (!type_q || bitCnt_q >= 3'd3) begin
          crcBit = (type_q && bitCnt_q == 3'd7) ? 1'b0 : sin;
          crcFb  = crc_q[2] ^ crcBit;
          crc_d  = {crc_q[1], crc_q[0] ^ crcFb, crcFb};
        end
`endif
        if (bitCnt_q == 3'd0) state_d = STOP;
        else                  bitCnt_d = bitCnt_q - 3'd1;
      end
      STOP: begin
        if (!sin) begin
          frameErr_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_HI;
        end else begin
          state_d = IDLE;
          if (!type_q) begin
            if (cnt_q != LAST_CNT) begin
              acc_d = {acc_q[23:0], byte_q};
              cnt_d = cnt_q + CW'(1);
            end else begin
              pktErr_d = 1'b1;
              cnt_d    = '0;
            end
          end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (crcOk) begin
              complete = 1'b1;
              cplData  = acc_q;
            end else begin
              pktErr_d = 1'b1;
            end
          end else if (cnt_q == '0 && byte_q[7]) begin
            complete = 1'b1;
            cplErr   = 1'b1;
          end else begin
            pktErr_d = 1'b1;
            cnt_d    = '0;
          end
        end
      end
      WAIT_HI: begin
        if (sin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake: an accept and a fresh load may happen on the same clock.
    if (resValid_q && res_ready) resValid_d = 1'b0;
    if (complete) begin
      if (!resValid_q || res_ready) begin
        resValid_d = 1'b1;
        resData_d  = cplData;
        resCtl_d   = byte_q;
        resErr_d   = cplErr;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      type_q     <= 1'b0;
      byte_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resCtl_q   <= '0;
      resErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
      pktErr_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      type_q     <= type_d;
      byte_q     <= byte_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      resValid_q <= resValid_d;
      resData_q  <= resData_d;
      resCtl_q   <= resCtl_d;
      resErr_q   <= resErr_d;
      frameErr_q <= frameErr_d;
      pktErr_q   <= pktErr_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef MTM_RX_CRC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end
`endif

  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_ctl   = resCtl_q;
  assign res_err   = resErr_q;
  assign frame_err = frameErr_q;
  assign pkt_err   = pktErr_q;
  assign overrun   = overrun_q;

endmodule
